// File: rtl/sha256_round_engine.sv
// Iterative SHA-256 compression engine: ROUNDS_PER_CYCLE rounds per clock,
// message schedule expanded on the fly in a 16-word sliding window.
module sha256_round_engine #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1,
  parameter int unsigned FEED_FORWARD     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         in_ready,
  input  logic [511:0] block_in,
  input  logic [255:0] state_in,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest_out,
  output logic [5:0]   round_idx
);

  localparam int unsigned R        = ROUNDS_PER_CYCLE;
  localparam int unsigned WIN      = 16;
  localparam logic [5:0]  LAST_CNT = 6'(64 - R);
  localparam logic [5:0]  CNT_STEP = 6'(R);

  // Only power-of-two unroll factors that divide 64 are supported.
  if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds_per_cycle
    $error("sha256_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_e;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_e                 state_q, state_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [WIN-1:0][31:0]   win_q, win_d;      // win_q[0] = W[cnt]
  logic [7:0][31:0]       work_q, work_d;    // [7] = a ... [0] = h
  logic [7:0][31:0]       save_q, save_d;
  logic [7:0][31:0]       digest_q, digest_d;
  logic                   out_valid_q, out_valid_d;
  logic                   in_ready_q, in_ready_d;
  logic                   busy_q, busy_d;
  logic [5:0]             round_idx_q, round_idx_d;

  logic [WIN+R-1:0][31:0] ext;
  logic [31:0]            va, vb, vc, vd, ve, vf, vg, vh, t1, t2;

  // Unrolled round chain: extend the schedule by R words and run R rounds.
  always_comb begin
    t1 = '0;
    t2 = '0;
    for (int unsigned i = 0; i < WIN; i++) ext[i] = win_q[i];
    for (int unsigned i = 0; i < R; i++) begin
      ext[WIN+i] = ssig1(ext[14+i]) + ext[9+i] + ssig0(ext[1+i]) + ext[i];
    end
    {va, vb, vc, vd, ve, vf, vg, vh} = work_q;
    for (int unsigned i = 0; i < R; i++) begin
      t1 = vh + bsig1(ve) + ((ve & vf) ^ (~ve & vg)) + K_ROM[cnt_q + 6'(i)] + ext[i];
      t2 = bsig0(va) + ((va & vb) ^ (va & vc) ^ (vb & vc));
      vh = vg;
      vg = vf;
      vf = ve;
      ve = vd + t1;
      vd = vc;
      vc = vb;
      vb = va;
      va = t1 + t2;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    work_d      = work_q;
    save_d      = save_q;
    digest_d    = digest_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          for (int unsigned i = 0; i < WIN; i++) win_d[i] = block_in[511-32*i -: 32];
          work_d  = state_in;
          save_d  = state_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < WIN; i++) win_d[i] = ext[R+i];
        work_d = {va, vb, vc, vd, ve, vf, vg, vh};
        cnt_d  = cnt_q + CNT_STEP;
        if (cnt_q == LAST_CNT) state_d = FINAL;
      end
      FINAL: begin
        for (int unsigned k = 0; k < 8; k++) begin
          digest_d[k] = (FEED_FORWARD != 0) ? work_q[k] + save_q[k] : work_q[k];
        end
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d == RUN) || (state_d == FINAL);
    round_idx_d = (state_d == RUN) ? cnt_d : 6'd0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      win_q       <= '0;
      work_q      <= '0;
      save_q      <= '0;
      digest_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      round_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      work_q      <= work_d;
      save_q      <= save_d;
      digest_q    <= digest_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      round_idx_q <= round_idx_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign digest_out = digest_q;
  assign round_idx  = round_idx_q;

endmodule
